// File: rtl/mult_sequencer.sv
// Sequencer for the shared multiplier: reads (A,B) operand pairs from RAM, formats them per mode,
// hands them to the multiplier over valid/ready and streams mode-extended products to the consumer.
module mult_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [4:0]        num_pairs,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mul_valid,
    input  logic              mul_ready,
    output logic [1:0]        mul_mode,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic              mul_done,
    input  logic [DATA_W-1:0] mul_product,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [4:0]        res_index,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_ISSUE, S_WAIT, S_OUT, S_FIN
    } state_t;

    state_t            state, state_next;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [4:0]        npairs_q;
    logic [4:0]        idx;
    logic [TW-1:0]     timer;
    logic [31:0]       a_q, b_q;
    logic [DATA_W-1:0] res_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic              timed_out;
    logic              unused_rdata;

    assign unused_rdata = ^mem_rdata[DATA_W-1:32];

    assign addr_a    = base_q + ADDR_W'({idx, 1'b0});
    assign addr_b    = addr_a + ADDR_W'(1);
    assign timed_out = (timer == TW'(TIMEOUT - 1));

    function automatic logic [31:0] fmt_op(input logic [1:0] m, input logic [31:0] w);
        case (m)
            2'd0:    return {24'b0, w[7:0]};
            2'd1:    return {{24{w[7]}}, w[7:0]};
            2'd2:    return {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] ext_prod(input logic [1:0] m, input logic [DATA_W-1:0] p);
        case (m)
            2'd0:    return {{(DATA_W-16){1'b0}}, p[15:0]};
            2'd1:    return {{(DATA_W-16){p[15]}}, p[15:0]};
            2'd2:    return {{(DATA_W-32){p[31]}}, p[31:0]};
            default: return p;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        mul_valid  = 1'b0;
        res_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:  if (start) state_next = (num_pairs == 5'd0) ? S_FIN : S_RD_A;
            S_RD_A: begin
                mem_rd     = 1'b1;
                mem_addr   = addr_a;
                state_next = S_RD_B;
            end
            S_RD_B: begin
                mem_rd     = 1'b1;
                mem_addr   = addr_b;
                state_next = S_CAP_B;
            end
            S_CAP_B: state_next = S_ISSUE;
            S_ISSUE: begin
                mul_valid = 1'b1;
                if (mul_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done)       state_next = S_OUT;
                else if (timed_out) state_next = S_FIN;
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) state_next = ((idx + 5'd1) == npairs_q) ? S_FIN : S_RD_A;
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operands are formatted as they are captured so mul_a/mul_b stay stable through ISSUE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q   <= '0;
            base_q   <= '0;
            npairs_q <= '0;
            idx      <= '0;
            timer    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mode_q   <= mode;
                    base_q   <= base_addr;
                    npairs_q <= num_pairs;
                    idx      <= '0;
                    err_q    <= 1'b0;
                end
                S_RD_B:  a_q   <= fmt_op(mode_q, mem_rdata[31:0]);
                S_CAP_B: b_q   <= fmt_op(mode_q, mem_rdata[31:0]);
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    if (mul_done)       res_q <= ext_prod(mode_q, mul_product);
                    else if (timed_out) err_q <= 1'b1;
                    else                timer <= timer + TW'(1);
                end
                S_OUT:   if (res_ready) idx <= idx + 5'd1;
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign mul_mode  = mode_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign res_data  = res_q;
    assign res_index = idx;
    assign err       = err_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: RAM and multiplier models, expected streams from an integer
// reference of each job, and a monitor that checks addresses, operands, results and done timing.
module tb_mult_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [4:0]  base_addr;
    logic [4:0]  num_pairs;
    logic        mem_rd;
    logic [4:0]  mem_addr;
    logic [63:0] mem_rdata;
    logic        mul_valid;
    logic        mul_ready;
    logic [1:0]  mul_mode;
    logic [31:0] mul_a, mul_b;
    logic        mul_done;
    logic [63:0] mul_product;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic [4:0]  res_index;
    logic        busy, done, err;

    always #5 clock = ~clock;

    mult_sequencer #(.ADDR_W(5), .DATA_W(64), .TIMEOUT(64)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .base_addr(base_addr), .num_pairs(num_pairs),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_mode(mul_mode),
        .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_product(mul_product),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_index(res_index), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
    } res_t;

    res_t        res_q[$];
    logic [4:0]  addr_q[$];
    logic [63:0] op_q[$];
    logic [63:0] ram[32];

    int tests = 0;
    int fails = 0;

    bit no_done   = 1'b0;
    int bp_hold   = 0;
    int ready_pct = 70;
    int lat_max   = 3;
    int done_cnt  = 0;
    int hs_total  = 0;
    int gap_hs    = 0;
    int gap_res   = 0;
    int last_gap_hs  = 0;
    int last_gap_res = 0;
    logic last_err   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand value as an integer, straight from the mode's definition.
    function automatic longint opval(input logic [1:0] m, input logic [63:0] w);
        byte     sb;
        shortint ss;
        case (m)
            2'd0: return longint'(w[7:0]);
            2'd1: begin sb = w[7:0];  return longint'(sb); end
            2'd2: begin ss = w[15:0]; return longint'(ss); end
            default: return longint'(w[31:0]);
        endcase
    endfunction

    // Environment: RAM, multiplier, consumer, and the checking monitor.
    initial begin
        bit          rd_pend = 1'b0;
        logic [4:0]  rd_a    = '0;
        bit          hs      = 1'b0;
        bit          mbusy   = 1'b0;
        int          cnt     = 0;
        logic [63:0] prod    = '0;
        logic [63:0] g;
        bit          stall   = 1'b0;
        logic [63:0] sd      = '0;
        logic [4:0]  si      = '0;
        res_t        r;
        forever begin
            @(negedge clock);
            gap_hs++;
            gap_res++;
            if (!reset) begin
                rd_pend = 1'b0; hs = 1'b0; mbusy = 1'b0; stall = 1'b0;
            end else begin
                if (stall) begin
                    check("stall_valid", 64'(res_valid), 64'd1);
                    check("stall_data", res_data, sd);
                    check("stall_index", 64'(res_index), 64'(si));
                end
                if (res_valid) check("no_read_in_out", 64'(mem_rd), 64'd0);
                if (mem_rd) begin
                    rd_pend = 1'b1;
                    rd_a    = mem_addr;
                    if (addr_q.size() == 0) check("extra_read", 64'(mem_addr), 64'hFFFF);
                    else                    check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
                end
                if (mul_valid && mul_ready) begin
                    hs = 1'b1;
                    hs_total++;
                    gap_hs = 0;
                    if (op_q.size() == 0) check("extra_issue", {mul_a, mul_b}, 64'hFFFF);
                    else                  check("operands", {mul_a, mul_b}, op_q.pop_front());
                    g = {$urandom(), $urandom()};
                    case (mul_mode)
                        2'd0: begin prod = {32'b0, mul_a} * {32'b0, mul_b}; prod = {g[63:16], prod[15:0]}; end
                        2'd1: begin prod = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b}; prod = {g[63:16], prod[15:0]}; end
                        2'd2: begin prod = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b}; prod = {g[63:32], prod[31:0]}; end
                        default: prod = {32'b0, mul_a} * {32'b0, mul_b};
                    endcase
                end
                if (res_valid && res_ready) begin
                    gap_res = 0;
                    stall   = 1'b0;
                    if (res_q.size() == 0) check("extra_result", res_data, 64'hFFFF);
                    else begin
                        r = res_q.pop_front();
                        check("res_index", 64'(res_index), 64'(r.idx));
                        check("res_data", res_data, r.data);
                    end
                end else if (res_valid) begin
                    stall = 1'b1; sd = res_data; si = res_index;
                end else stall = 1'b0;
                if (done) begin
                    done_cnt++;
                    last_gap_hs  = gap_hs;
                    last_gap_res = gap_res;
                    last_err     = err;
                end
            end
            @(posedge clock);
            #1;
            mul_done    = 1'b0;
            mul_product = {$urandom(), $urandom()};
            if (rd_pend) begin mem_rdata = ram[rd_a]; rd_pend = 1'b0; end
            else mem_rdata = {$urandom(), $urandom()};
            if (hs) begin hs = 1'b0; mbusy = 1'b1; cnt = $urandom_range(lat_max, 0); end
            else if (mbusy && cnt > 0) cnt--;
            if (mbusy && cnt == 0 && !no_done) begin
                mul_done = 1'b1; mul_product = prod; mbusy = 1'b0;
            end
            mul_ready = ($urandom_range(99, 0) < ready_pct);
            if (bp_hold > 0) begin
                res_ready = 1'b0;
                if (res_valid) bp_hold--;
            end else res_ready = ($urandom_range(99, 0) < ready_pct);
        end
    end

    task automatic push_job(input logic [1:0] m, input logic [4:0] b, input logic [4:0] n, input bit first_only);
        logic [4:0] aa;
        longint     va, vb;
        res_t       r;
        for (int i = 0; i < int'(n); i++) begin
            aa = b + 5'(2 * i);
            va = opval(m, ram[aa]);
            vb = opval(m, ram[5'(aa + 5'd1)]);
            addr_q.push_back(aa);
            addr_q.push_back(5'(aa + 5'd1));
            op_q.push_back({va[31:0], vb[31:0]});
            if (first_only) break;
            r.idx  = 5'(i);
            r.data = 64'(va * vb);
            res_q.push_back(r);
        end
    endtask

    task automatic run_job(input logic [1:0] m, input logic [4:0] b, input logic [4:0] n,
                           input bit expect_to, input bit fast);
        int prev;
        int it;
        bit got = 1'b0;
        push_job(m, b, n, expect_to);
        prev = done_cnt;
        @(posedge clock); #1;
        start = 1'b1; mode = m; base_addr = b; num_pairs = n;
        @(posedge clock); #1;
        start = 1'b0; mode = 2'($urandom()); base_addr = 5'($urandom()); num_pairs = 5'($urandom());
        for (it = 1; it <= 6000; it++) begin
            @(negedge clock); #1;
            if (done_cnt != prev) begin got = 1'b1; break; end
            if (it == 3 && n != 5'd0) start = 1'b1;
            if (it == 4) start = 1'b0;
        end
        start = 1'b0;
        check("done_seen", 64'(got), 64'd1);
        check("err_at_done", 64'(last_err), 64'(expect_to));
        if (n == 5'd0)     check("done_gap_empty", 64'(it), 64'd1);
        else if (expect_to) check("timeout_wait_cycles", 64'(last_gap_hs), 64'd65);
        else               check("done_after_last_res", 64'(last_gap_res), 64'd1);
        if (fast) check("min_throughput", 64'(it), 64'(6 * int'(n) + 1));
        check("results_left", 64'(res_q.size()), 64'd0);
        check("reads_left", 64'(addr_q.size()), 64'd0);
        check("issues_left", 64'(op_q.size()), 64'd0);
        @(negedge clock);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_job", 64'(busy), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, 64'({mem_rd, mem_addr, mul_valid, mul_mode, res_valid, res_index, busy, done, err}), 64'd0);
        check({tag, "_mul_ab"}, {mul_a, mul_b}, 64'd0);
        check({tag, "_res_data"}, res_data, 64'd0);
    endtask

    initial begin
        int prev;
        bit got;
        reset = 1'b0; start = 1'b0; mode = '0; base_addr = '0; num_pairs = '0;
        mem_rdata = '0; mul_ready = 1'b0; mul_done = 1'b0; mul_product = '0; res_ready = 1'b0;
        for (int i = 0; i < 32; i++) ram[i] = {$urandom(), $urandom()};
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        @(posedge clock); #1 reset = 1'b1;

        ram[0] = 64'hDEADBEEF_123456FF;
        ram[1] = 64'h01234567_89ABCDFF;
        run_job(2'd0, 5'd0, 5'd1, 1'b0, 1'b0);

        ram[4] = 64'h00000000_00000080;
        ram[5] = 64'hFFFF0000_00000002;
        run_job(2'd1, 5'd4, 5'd1, 1'b0, 1'b0);

        run_job(2'($urandom()), 5'd30, 5'd2, 1'b0, 1'b0);

        bp_hold = 10;
        run_job(2'd2, 5'($urandom()), 5'd2, 1'b0, 1'b0);

        ready_pct = 100; lat_max = 0;
        run_job(2'd3, 5'($urandom()), 5'd4, 1'b0, 1'b1);
        ready_pct = 70;  lat_max = 3;

        no_done = 1'b1;
        run_job(2'($urandom()), 5'($urandom()), 5'd3, 1'b1, 1'b0);
        no_done = 1'b0;
        repeat (3) @(negedge clock);
        check("err_sticky", 64'(err), 64'd1);

        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < 32; i++) ram[i] = {$urandom(), $urandom()};
            run_job(2'($urandom()), 5'($urandom()), 5'($urandom_range(6, 0)), 1'b0, 1'b0);
        end
        run_job(2'($urandom()), 5'($urandom()), 5'd31, 1'b0, 1'b0);

        no_done = 1'b1;
        push_job(2'd1, 5'd7, 5'd2, 1'b1);
        prev = hs_total;
        got  = 1'b0;
        @(posedge clock); #1;
        start = 1'b1; mode = 2'd1; base_addr = 5'd7; num_pairs = 5'd2;
        @(posedge clock); #1 start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock); #1;
            if (hs_total != prev) begin got = 1'b1; break; end
        end
        check("reached_wait", 64'(got), 64'd1);
        repeat (5) @(negedge clock);
        prev = done_cnt;
        #2 reset = 1'b0;
        #1;
        check_outputs_zero("midjob_reset");
        repeat (3) @(posedge clock);
        check("no_done_on_abort", 64'(done_cnt), 64'(prev));
        res_q.delete(); addr_q.delete(); op_q.delete();
        no_done = 1'b0;
        #1 reset = 1'b1;
        run_job(2'($urandom()), 5'($urandom()), 5'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
